load_store_unit: RTL and testbench

Multi-cycle load/store unit between the RV32I core's memory-stage signals and a word-addressed data memory with a request/acknowledge bus and variable wait states. It accepts one load or store per handshake, checks alignment, and generates byte enables and replicated store data. On loads it extracts the addressed lane and sign- or zero-extends it. Every request ends in exactly one response pulse, including the error cases (misaligned, illegal funct3, bus timeout).

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/load_store_unit_if.sv | 40 ++++
 rtl/load_store_unit_align.sv | 28 ++
 rtl/load_store_unit.sv | 114 +++++++++++
 tb/tb_load_store_unit.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and request-decoding helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_H, F3_HU: return ~lo[0];
            F3_W:        return lo == 2'b00;
            default:     return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_B:    return 4'b0001 << lo;
            F3_H:    return 4'b0011 << {lo[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        case (f3)
            F3_B:    return {4{wd[7:0]}};
            F3_H:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response interface and memory-side bus interface of the LSU.
interface lsu_core_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/load_store_unit_align.sv
// Combinational load-lane extraction with sign/zero extension; shared with the pipelined core.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        shifted   = rdata_i >> {addr_lo_i, 3'b000};
        byte_lane = shifted[7:0];
        half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_B:    data_o = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   data_o = {24'd0, byte_lane};
            F3_H:    data_o = {{16{half_lane[15]}}, half_lane};
            F3_HU:   data_o = {16'd0, half_lane};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit: request latch, IDLE/BUS/RESP FSM, bus wait timeout.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       reset,
    lsu_core_if.slave  core,
    lsu_mem_if.master  mem
);

    localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        accept;
    logic        in_bus;
    logic [7:0]  cnt_inc;
    logic [31:0] ld_data;

    assign accept  = core.req_valid && (state_q == IDLE);
    assign in_bus  = (state_q == BUS);
    assign cnt_inc = cnt_q + 8'd1;

    load_align u_align (
        .rdata_i   (mem.mem_rdata),
        .addr_lo_i (addr_q[1:0]),
        .funct3_i  (f3_q),
        .data_o    (ld_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = 8'd0;
                    if (funct3_legal(core.req_we, core.req_funct3) &&
                        addr_aligned(core.req_funct3, core.req_addr[1:0])) begin
                        state_d = BUS;
                    end else begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                    end
                end
            end
            BUS: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (mem.mem_ack) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = we_q ? 32'd0 : ld_data;
                end else if (cnt_inc == TMO) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Request fields are only observed while in BUS, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= core.req_we;
            f3_q    <= core.req_funct3;
            addr_q  <= core.req_addr;
            wdata_q <= core.req_wdata;
        end
    end

    assign core.req_ready  = (state_q == IDLE);
    assign core.resp_valid = (state_q == RESP);
    assign core.resp_rdata = rdata_q;
    assign core.resp_err   = err_q;

    assign mem.mem_req   = in_bus;
    assign mem.mem_we    = in_bus && we_q;
    assign mem.mem_addr  = in_bus ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem.mem_be    = (in_bus && we_q) ? store_be(f3_q, addr_q[1:0]) : 4'b0000;
    assign mem.mem_wdata = in_bus ? store_data(f3_q, wdata_q) : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a behavioural request model.
module tb_load_store_unit;

    localparam int T = 15;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    lsu_core_if core ();
    lsu_mem_if  mem ();

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .reset (reset),
        .core  (core.slave),
        .mem   (mem.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Access size in bytes from the low two funct3 bits.
    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic legal_m(input logic we, input logic [2:0] f3);
        if (f3[1:0] == 2'b11 || f3 > 3'd5) return 1'b0;
        if (we && f3[2]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] load_m(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
        logic [31:0] mask;
        logic [31:0] v;
        int          sz;
        sz = size_of(f3);
        if (sz == 4) return word;
        mask = (sz == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        v = (word >> (8 * (addr % 4))) & mask;
        if (!f3[2] && v > (mask >> 1)) v = v | ~mask;
        return v;
    endfunction

    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int waits, input logic [31:0] word);
        logic        bad;
        logic        acked;
        logic [31:0] exp_rd;
        logic [31:0] exp_be;
        logic [31:0] exp_wd;
        int          k;
        int          sz;
        sz  = size_of(f3);
        bad = !legal_m(we, f3) || ((addr % sz) != 0);
        exp_be = ((32'd1 << sz) - 1) << (addr % 4);
        exp_wd = (sz == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
                 (sz == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
        @(negedge clk);
        chk_eq("req_ready_idle", 32'(core.req_ready), 32'd1);
        core.req_valid  = 1'b1;
        core.req_we     = we;
        core.req_funct3 = f3;
        core.req_addr   = addr;
        core.req_wdata  = wd;
        @(posedge clk);
        #1;
        core.req_valid = 1'b0;
        core.req_addr  = $urandom;
        core.req_wdata = $urandom;
        acked  = 1'b0;
        exp_rd = 32'd0;
        if (bad) begin
            chk_eq("err_resp_valid", 32'(core.resp_valid), 32'd1);
            chk_eq("err_resp_err", 32'(core.resp_err), 32'd1);
            chk_eq("err_resp_rdata", core.resp_rdata, 32'd0);
            chk_eq("err_mem_req", 32'(mem.mem_req), 32'd0);
        end else begin
            k = 0;
            while (!acked && k < T) begin
                k++;
                chk_eq("bus_mem_req", 32'(mem.mem_req), 32'd1);
                chk_eq("bus_mem_addr", mem.mem_addr, addr & 32'hFFFF_FFFC);
                chk_eq("bus_mem_we", 32'(mem.mem_we), 32'(we));
                chk_eq("bus_mem_be", 32'(mem.mem_be), we ? exp_be : 32'd0);
                if (we) chk_eq("bus_mem_wdata", mem.mem_wdata, exp_wd);
                chk_eq("bus_resp_valid", 32'(core.resp_valid), 32'd0);
                if (k == waits + 1) begin
                    mem.mem_ack   = 1'b1;
                    mem.mem_rdata = word;
                    acked         = 1'b1;
                end else begin
                    mem.mem_rdata = $urandom;
                end
                @(posedge clk);
                #1;
                mem.mem_ack = 1'b0;
            end
            if (acked && !we) exp_rd = load_m(f3, addr, word);
            chk_eq("resp_valid", 32'(core.resp_valid), 32'd1);
            chk_eq("resp_err", 32'(core.resp_err), 32'(!acked));
            chk_eq("resp_rdata", core.resp_rdata, exp_rd);
            chk_eq("resp_mem_req", 32'(mem.mem_req), 32'd0);
            chk_eq("resp_mem_be", 32'(mem.mem_be), 32'd0);
            chk_eq("resp_mem_addr", mem.mem_addr, 32'd0);
        end
        @(posedge clk);
        #1;
        chk_eq("after_resp_valid", 32'(core.resp_valid), 32'd0);
        chk_eq("after_req_ready", 32'(core.req_ready), 32'd1);
        chk_eq("held_rdata", core.resp_rdata, exp_rd);
        chk_eq("held_err", 32'(core.resp_err), 32'(bad || !acked));
        // A stray ack in IDLE must not produce a response.
        mem.mem_ack = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        mem.mem_ack = 1'b0;
        chk_eq("idle_ack_ignored", 32'(core.resp_valid), 32'd0);
    endtask

    initial begin
        logic [2:0] f3;
        logic       we;
        int         waits;
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b0;
        core.req_valid  = 1'b0;
        core.req_we     = 1'b0;
        core.req_funct3 = 3'd0;
        core.req_addr   = 32'd0;
        core.req_wdata  = 32'd0;
        mem.mem_ack     = 1'b0;
        mem.mem_rdata   = 32'd0;
        #1;
        chk_eq("rst_req_ready", 32'(core.req_ready), 32'd1);
        chk_eq("rst_resp_valid", 32'(core.resp_valid), 32'd0);
        chk_eq("rst_resp_err", 32'(core.resp_err), 32'd0);
        chk_eq("rst_resp_rdata", core.resp_rdata, 32'd0);
        chk_eq("rst_mem_req", 32'(mem.mem_req), 32'd0);
        chk_eq("rst_mem_we", 32'(mem.mem_we), 32'd0);
        chk_eq("rst_mem_be", 32'(mem.mem_be), 32'd0);
        chk_eq("rst_mem_addr", mem.mem_addr, 32'd0);
        chk_eq("rst_mem_wdata", mem.mem_wdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        run_txn(1'b0, 3'b000, 32'h67, 32'h0, 0, 32'h80FF_1234);
        run_txn(1'b1, 3'b001, 32'h66, 32'h0000_ABCD, 3, 32'h0);
        run_txn(1'b0, 3'b010, 32'h62, 32'h0, 0, 32'h0);
        run_txn(1'b1, 3'b100, 32'h60, 32'h1234_5678, 0, 32'h0);
        run_txn(1'b0, 3'b010, 32'h64, 32'h0, 1000, 32'hDEAD_BEEF);
        run_txn(1'b0, 3'b010, 32'h64, 32'h0, T - 1, 32'hDEAD_BEEF);

        // Reset in the second BUS cycle discards the request.
        @(negedge clk);
        core.req_valid  = 1'b1;
        core.req_we     = 1'b0;
        core.req_funct3 = 3'b010;
        core.req_addr   = 32'h64;
        @(posedge clk);
        #1;
        core.req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_eq("midbus_mem_req", 32'(mem.mem_req), 32'd1);
        reset = 1'b0;
        #1;
        chk_eq("async_rst_mem_req", 32'(mem.mem_req), 32'd0);
        chk_eq("async_rst_req_ready", 32'(core.req_ready), 32'd1);
        chk_eq("async_rst_resp_valid", 32'(core.resp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_eq("post_rst_no_resp", 32'(core.resp_valid), 32'd0);
        end
        run_txn(1'b0, 3'b101, 32'h64, 32'h0, 1, 32'h1234_F00D);

        for (int n = 0; n < 250; n++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
            else if (we) f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd5;
            end
            case ($urandom_range(0, 7))
                0:       waits = T - 1;
                1:       waits = T + 5;
                default: waits = $urandom_range(0, 5);
            endcase
            run_txn(we, f3, $urandom, $urandom, waits, $urandom);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
